vector_compress_unit: RTL and testbench

- Multi-cycle integer vector unit implementing vcompress.vm on a 128-bit register (VLEN=128). It is the packing counterpart of the combinational mask-select merge unit.
- Walks the source elements one per cycle. Each element whose mask bit is set is written into the next free low-order slot of vd.
- Slots that are not filled keep the old destination value.
- Sits in the integer functional-unit group. The issue stage drives it with a start pulse; writeback samples it on done_o.

---
 rtl/vector_int_pkg.sv | 43 ++++
 rtl/vector_element_lane_mux.sv | 61 ++++++
 rtl/vector_compress_unit.sv | 162 ++++++++++++++++
 tb/tb_vector_compress_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_int_pkg.sv
// Shared encodings, constants and small helpers for the integer vector
// functional-unit group (compress, slide, gather, ...).
package vector_int_pkg;

    localparam int VLEN   = 128;
    localparam int MASK_W = VLEN / 8;

    // Element-width encodings (vsew). Any value with bit 2 set is reserved.
    localparam logic [2:0] VSEW_8  = 3'b000;
    localparam logic [2:0] VSEW_16 = 3'b001;
    localparam logic [2:0] VSEW_32 = 3'b010;
    localparam logic [2:0] VSEW_64 = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } compress_state_t;

    // True when the element-width encoding is not one of the four legal widths.
    function automatic logic sew_reserved(input logic [2:0] vsew);
        return vsew[2];
    endfunction

    // Index of the last element in a register: (16 >> sew) - 1.
    function automatic logic [3:0] last_index(input logic [1:0] sew);
        return 4'd15 >> sew;
    endfunction

    // Mask bits that refer to real elements for this width; higher bits are ignored.
    function automatic logic [MASK_W-1:0] active_mask(input logic [1:0] sew);
        logic [MASK_W-1:0] m;
        case ({1'b0, sew})
            VSEW_8:  m = 16'hFFFF;
            VSEW_16: m = 16'h00FF;
            VSEW_32: m = 16'h000F;
            VSEW_64: m = 16'h0003;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vector_element_lane_mux.sv
// Element lane mux: extracts element `idx` of `src` at the given width and
// inserts an element into slot `slot` of `dst` using a per-byte enable.
// Purely combinational, so slide/gather units can reuse it unchanged.
module vector_element_lane_mux
    import vector_int_pkg::*;
(
    input  logic [1:0]      sew,
    input  logic [VLEN-1:0] src,
    input  logic [3:0]      idx,
    output logic [63:0]     elem,
    input  logic [VLEN-1:0] dst,
    input  logic [3:0]      slot,
    input  logic [63:0]     ins_elem,
    output logic [VLEN-1:0] merged
);

    logic [7:0]        src_bytes [MASK_W];
    logic [7:0]        ins_bytes [8];
    logic [3:0]        ew_bytes;
    logic [3:0]        rd_base;
    logic [3:0]        wr_base;
    logic [MASK_W-1:0] byte_en;

    assign ew_bytes = 4'd1 << sew;
    assign rd_base  = idx << sew;
    assign wr_base  = slot << sew;

    genvar gi;

    // Byte views of the source vector and of the element being inserted.
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_src_bytes
            assign src_bytes[gi] = src[gi*8 +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_ins_bytes
            assign ins_bytes[gi] = ins_elem[gi*8 +: 8];
        end
    endgenerate

    // Extraction: element byte gi comes from source byte rd_base+gi; bytes
    // beyond the element width read as zero.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_extract
            logic [3:0] rd_sel;
            assign rd_sel = rd_base + 4'(gi);
            assign elem[gi*8 +: 8] = (4'(gi) < ew_bytes) ? src_bytes[rd_sel] : 8'h00;
        end
    endgenerate

    // Insertion: destination bytes inside the target slot take the matching
    // element byte, every other byte keeps its old value.
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_insert
            logic [4:0] rel;
            assign rel = 5'(gi) - {1'b0, wr_base};
            assign byte_en[gi] = (5'(gi) >= {1'b0, wr_base}) && (rel < {1'b0, ew_bytes});
            assign merged[gi*8 +: 8] = byte_en[gi] ? ins_bytes[rel[2:0]] : dst[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/vector_compress_unit.sv
// vector_compress_unit: multi-cycle vcompress.vm on a 128-bit register.
// Walks the source one element per cycle and packs every element whose mask
// bit is set into the next free low slot of the destination; unfilled slots
// keep the old destination value.
// Optional build macro: VECTOR_COMPRESS_EARLY_EXIT_EN -- finish as soon as no
// set mask bits remain above the current element (results are unchanged).
module vector_compress_unit
    import vector_int_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              chip_enable_i,
    input  logic              start_i,
    input  logic [2:0]        vsew_i,
    input  logic [VLEN-1:0]   vs2_i,
    input  logic [MASK_W-1:0] vmask_i,
    input  logic [VLEN-1:0]   vd_old_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [4:0]        count_o,
    output logic [VLEN-1:0]   vd_o
);

    compress_state_t   state_reg, state_next;

    logic [1:0]        sew_reg;
    logic [VLEN-1:0]   src_reg;
    logic [MASK_W-1:0] mask_reg;
    logic [VLEN-1:0]   work_reg;
    logic [3:0]        idx_reg;
    logic [3:0]        last_idx_reg;
    logic [4:0]        wp_reg;
    logic              err_reg;

    logic [VLEN-1:0]   vd_out_reg;
    logic [4:0]        count_reg;
    logic              done_reg;
    logic              error_out_reg;

    logic              accept;
    logic              step;
    logic              finish;
    logic              last_step;
    logic [63:0]       elem;
    logic [VLEN-1:0]   merged;

`ifdef VECTOR_COMPRESS_EARLY_EXIT_EN
    logic [MASK_W-1:0] remaining;

    // Set mask bits strictly above the element handled this cycle; when none
    // remain the walk can stop after this element.
    assign remaining = mask_reg >> ({1'b0, idx_reg} + 5'd1);
    assign last_step = (idx_reg == last_idx_reg) || (remaining == '0);
`else
    assign last_step = (idx_reg == last_idx_reg);
`endif

    vector_element_lane_mux u_lane_mux (
        .sew      (sew_reg),
        .src      (src_reg),
        .idx      (idx_reg),
        .elem     (elem),
        .dst      (work_reg),
        .slot     (wp_reg[3:0]),
        .ins_elem (elem),
        .merged   (merged)
    );

    // Next-state and step decode; a low chip enable freezes RUN and DONE.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i && chip_enable_i) begin
                    accept     = 1'b1;
                    state_next = sew_reserved(vsew_i) ? DONE : RUN;
                end
            end
            RUN: begin
                if (chip_enable_i) begin
                    step = 1'b1;
                    if (last_step) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (chip_enable_i) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture and the per-element pack step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sew_reg      <= 2'b00;
            src_reg      <= '0;
            mask_reg     <= '0;
            work_reg     <= '0;
            idx_reg      <= 4'd0;
            last_idx_reg <= 4'd0;
            wp_reg       <= 5'd0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            sew_reg      <= vsew_i[1:0];
            src_reg      <= vs2_i;
            mask_reg     <= vmask_i & active_mask(vsew_i[1:0]);
            work_reg     <= vd_old_i;
            idx_reg      <= 4'd0;
            last_idx_reg <= last_index(vsew_i[1:0]);
            wp_reg       <= 5'd0;
            err_reg      <= sew_reserved(vsew_i);
        end else if (step) begin
            if (mask_reg[idx_reg]) begin
                work_reg <= merged;
                wp_reg   <= wp_reg + 5'd1;
            end
            idx_reg <= idx_reg + 4'd1;
        end
    end

    // Result registers: published on the DONE cycle, held until the next one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vd_out_reg    <= '0;
            count_reg     <= 5'd0;
            done_reg      <= 1'b0;
            error_out_reg <= 1'b0;
        end else begin
            done_reg      <= finish;
            error_out_reg <= finish && err_reg;
            if (finish) begin
                vd_out_reg <= work_reg;
                count_reg  <= wp_reg;
            end
        end
    end

    assign busy_o  = (state_reg != IDLE);
    assign done_o  = done_reg;
    assign error_o = error_out_reg;
    assign count_o = count_reg;
    assign vd_o    = vd_out_reg;

endmodule

// File: tb/tb_vector_compress_unit.sv
// Testbench for vector_compress_unit: directed cases plus randomized ops,
// checked by a scoreboard against a behavioural compress model.
module tb_vector_compress_unit;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         chip_enable_i;
    logic         start_i;
    logic [2:0]   vsew_i;
    logic [127:0] vs2_i;
    logic [15:0]  vmask_i;
    logic [127:0] vd_old_i;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [4:0]   count_o;
    logic [127:0] vd_o;

    always #5 clk = ~clk;

    vector_compress_unit dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .chip_enable_i (chip_enable_i),
        .start_i       (start_i),
        .vsew_i        (vsew_i),
        .vs2_i         (vs2_i),
        .vmask_i       (vmask_i),
        .vd_old_i      (vd_old_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .count_o       (count_o),
        .vd_o          (vd_o)
    );

`ifdef VECTOR_COMPRESS_EARLY_EXIT_EN
    localparam int LAT_E32_DIR  = 4;
    localparam int LAT_E64_ZERO = 2;
`else
    localparam int LAT_E32_DIR  = 5;
    localparam int LAT_E64_ZERO = 3;
`endif

    typedef struct {
        logic [127:0] vd;
        logic [4:0]   cnt;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pack selected elements into low slots, from the rules alone.
    function automatic void ref_compress(input logic [2:0] sew, input logic [127:0] vs2,
                                         input logic [15:0] m, input logic [127:0] old,
                                         output logic [127:0] vd, output logic [4:0] cnt,
                                         output int lat);
        int ew, n, wp, last;
        vd  = old;
        cnt = 5'd0;
        if (sew[2]) begin
            lat = 1;
            return;
        end
        ew   = 1 << sew;
        n    = 16 / ew;
        wp   = 0;
        last = -1;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                for (int b = 0; b < ew; b++)
                    vd[(wp*ew + b)*8 +: 8] = vs2[(i*ew + b)*8 +: 8];
                wp++;
                last = i;
            end
        end
        cnt = 5'(wp);
`ifdef VECTOR_COMPRESS_EARLY_EXIT_EN
        lat = (last < 0) ? 2 : last + 2;
`else
        lat = n + 1;
`endif
    endfunction

    // Monitor: every done_o pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("op done: cycle=%0d vd=%h count=%0d err=%0d", cyc, vd_o, count_o, error_o);
                check("vd", vd_o, mon_e.vd);
                check("count", 128'(count_o), 128'(mon_e.cnt));
                check("error", 128'(error_o), 128'(mon_e.err));
                check("latency_cycle", 128'(cyc), 128'(mon_e.done_cyc));
            end
        end else if (error_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL error_without_done: error_o=1 done_o=0 at cycle %0d, expected error_o=0", cyc);
        end
    end

    // Issue one op and wait for its done, with optional stall window and
    // noise on the inputs (including start pulses) while the unit is busy.
    task automatic do_op_exp(input logic [2:0] sew, input logic [127:0] vs2, input logic [15:0] m,
                             input logic [127:0] old, input logic [127:0] exp_vd,
                             input logic [4:0] exp_cnt, input logic exp_err, input int lat,
                             input int stall_at, input int stall_len, input bit noise);
        exp_t e;
        int   k;
        @(negedge clk);
        vsew_i        = sew;
        vs2_i         = vs2;
        vmask_i       = m;
        vd_old_i      = old;
        chip_enable_i = 1'b1;
        start_i       = 1'b1;
        e.vd       = exp_vd;
        e.cnt      = exp_cnt;
        e.err      = exp_err;
        e.done_cyc = cyc + 1 + lat + stall_len;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 128'(busy_o), 128'(1));
        k = 1;
        while (!done_o && k < 100) begin
            chip_enable_i = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            if (noise && busy_o) begin
                start_i  = 1'($urandom);
                vsew_i   = 3'($urandom);
                vs2_i    = {$urandom, $urandom, $urandom, $urandom};
                vmask_i  = 16'($urandom);
                vd_old_i = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_i       = 1'b0;
        chip_enable_i = 1'b1;
        if (!done_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done_o within %0d cycles of start, expected one", k);
        end
    endtask

    task automatic do_op_model(input logic [2:0] sew, input logic [127:0] vs2, input logic [15:0] m,
                               input logic [127:0] old, input int stall_at, input int stall_len,
                               input bit noise);
        logic [127:0] vd;
        logic [4:0]   cnt;
        int           lat;
        ref_compress(sew, vs2, m, old, vd, cnt, lat);
        do_op_exp(sew, vs2, m, old, vd, cnt, sew[2], lat, stall_at, stall_len, noise);
    endtask

    // Reset in the middle of an e16 run: the op is abandoned without done.
    task automatic reset_mid_run();
        @(negedge clk);
        vsew_i        = 3'b001;
        vs2_i         = {$urandom, $urandom, $urandom, $urandom};
        vmask_i       = 16'h0081;
        vd_old_i      = {$urandom, $urandom, $urandom, $urandom};
        chip_enable_i = 1'b1;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        $display("reset mid-run: busy=%0d vd=%h count=%0d done=%0d", busy_o, vd_o, count_o, done_o);
        check("rst_mid_busy", 128'(busy_o), 128'(0));
        check("rst_mid_vd", vd_o, 128'(0));
        check("rst_mid_count", 128'(count_o), 128'(0));
        check("rst_mid_done", 128'(done_o), 128'(0));
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]   sew;
        logic [15:0]  m;
        logic [127:0] vs2;
        logic [127:0] old;
        logic [127:0] dummy_vd;
        logic [4:0]   dummy_cnt;
        int           lat;
        int           s_at;
        int           s_len;

        rst_i         = 1'b1;
        chip_enable_i = 1'b0;
        start_i       = 1'b0;
        vsew_i        = 3'b000;
        vs2_i         = '0;
        vmask_i       = '0;
        vd_old_i      = '0;
        repeat (3) @(negedge clk);
        $display("reset: busy=%0d done=%0d err=%0d count=%0d vd=%h", busy_o, done_o, error_o, count_o, vd_o);
        check("reset_busy", 128'(busy_o), 128'(0));
        check("reset_done", 128'(done_o), 128'(0));
        check("reset_error", 128'(error_o), 128'(0));
        check("reset_count", 128'(count_o), 128'(0));
        check("reset_vd", vd_o, 128'(0));
        rst_i         = 1'b0;
        chip_enable_i = 1'b1;

        // e8: odd bytes packed low, upper half keeps 0xFF.
        do_op_exp(3'b000, 128'h0F0E0D0C0B0A0908_0706050403020100, 16'hAAAA, {128{1'b1}},
                  128'hFFFFFFFFFFFFFFFF_0F0D0B0907050301, 5'd8, 1'b0, 17, 0, 0, 1'b0);
        // e32: only element 2 selected; upper mask bits ignored.
        do_op_exp(3'b010, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 16'hFFF4,
                  {4{32'h5555_5555}}, {32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h3333_3333},
                  5'd1, 1'b0, LAT_E32_DIR, 0, 0, 1'b0);
        // e64 with empty mask.
        do_op_exp(3'b011, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 128'h1234,
                  128'h1234, 5'd0, 1'b0, LAT_E64_ZERO, 0, 0, 1'b0);
        // Reserved width.
        old = {$urandom, $urandom, $urandom, $urandom};
        do_op_exp(3'b101, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, old,
                  old, 5'd0, 1'b1, 1, 0, 0, 1'b0);
        // e16 with a 3-cycle enable drop mid-run and start pulses while busy.
        do_op_model(3'b001, {$urandom, $urandom, $urandom, $urandom}, 16'h00C5,
                    {$urandom, $urandom, $urandom, $urandom}, 3, 3, 1'b1);
        // Reset mid-run, then a normal op.
        reset_mid_run();
        do_op_model(3'b001, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);
        // Full e8 mask: count reaches 16.
        do_op_model(3'b000, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF,
                    {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);

        // Randomized ops.
        for (int t = 0; t < 40; t++) begin
            sew = ($urandom_range(0, 7) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            vs2 = {$urandom, $urandom, $urandom, $urandom};
            old = {$urandom, $urandom, $urandom, $urandom};
            ref_compress(sew, vs2, m, old, dummy_vd, dummy_cnt, lat);
            s_at  = 0;
            s_len = 0;
            if (lat > 1 && $urandom_range(0, 2) == 0) begin
                s_at  = $urandom_range(1, lat - 1);
                s_len = $urandom_range(1, 4);
            end
            do_op_model(sew, vs2, m, old, s_at, s_len, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
